kmeans_stream_tx: RTL

Frame source and result collector for the k-means clustering core. On a start pulse it sends one contiguous frame: CLUSTER_SIZE initial centroids followed by DATA_SIZE pseudo-random points from a seeded LFSR, on the core's `in_valid`/`in_data` input. It then waits for the core's burst of CLUSTER_SIZE final centroids and latches them. It drives the transmit side and consumes the output side of the core's streaming protocol, and serves as the on-chip self-test / bring-up driver.

---
 rtl/kmeans_stream_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/kmeans_stream_tx.sv
// rtl/kmeans_stream_tx.sv - frame source and result collector for the k-means core
// Sends init centroids then LFSR points as one contiguous frame, then captures the result burst.
module kmeans_stream_tx #(
  parameter int          CLUSTER_SIZE = 4,
  parameter int          DATA_SIZE    = 4096,
  parameter logic [23:0] TIMEOUT      = 24'hFF_FFFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [31:0]                  seed,
  input  logic [16*CLUSTER_SIZE-1:0]   init_c,
  output logic                         tx_valid,
  output logic [15:0]                  tx_data,
  input  logic                         rx_valid,
  input  logic [15:0]                  rx_data,
  output logic [16*CLUSTER_SIZE-1:0]   result,
  output logic                         result_valid,
  output logic                         done,
  output logic                         busy,
  output logic                         timeout_err,
  output logic                         proto_err,
  output logic [15:0]                  frame_xor
);

  localparam int          W       = $clog2(CLUSTER_SIZE + DATA_SIZE + 1);
  localparam int          RW      = 16 * CLUSTER_SIZE;
  localparam logic [W-1:0] C_LAST = W'(CLUSTER_SIZE - 1);
  localparam logic [W-1:0] D_LAST = W'(DATA_SIZE - 1);
  localparam logic [23:0] TO_LAST = TIMEOUT - 24'd1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND_INIT = 3'd1;
  localparam logic [2:0] S_SEND_DATA = 3'd2;
  localparam logic [2:0] S_WAIT_RES  = 3'd3;
  localparam logic [2:0] S_CAPTURE   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]    r_state;
  logic [31:0]   r_lfsr;
  logic [RW-1:0] r_init;
  logic [W-1:0]  r_cnt;
  logic [23:0]   r_wd;
  logic          r_tx_valid;
  logic [15:0]   r_tx_data;
  logic [RW-1:0] r_result;
  logic          r_result_valid;
  logic          r_done;
  logic          r_timeout_err;
  logic          r_proto_err;
  logic [15:0]   r_frame_xor;
  logic [31:0]   w_lfsr_next;

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h8020_0003) : (r_lfsr >> 1);

  // r_lfsr runs one step ahead of the word on tx_data during SEND_DATA.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_lfsr         <= 32'h1;
      r_init         <= '0;
      r_cnt          <= '0;
      r_wd           <= '0;
      r_tx_valid     <= 1'b0;
      r_tx_data      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_proto_err    <= 1'b0;
      r_frame_xor    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_lfsr         <= (seed == 32'h0) ? 32'h1 : seed;
            r_init         <= init_c >> 16;
            r_tx_valid     <= 1'b1;
            r_tx_data      <= init_c[15:0];
            r_cnt          <= '0;
            r_wd           <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_proto_err    <= 1'b0;
            r_frame_xor    <= '0;
            r_state        <= S_SEND_INIT;
          end
        end
        S_SEND_INIT: begin
          if (r_cnt == C_LAST) begin
            r_tx_data <= r_lfsr[15:0];
            r_lfsr    <= w_lfsr_next;
            r_cnt     <= '0;
            r_state   <= S_SEND_DATA;
          end else begin
            r_tx_data <= r_init[15:0];
            r_init    <= r_init >> 16;
            r_cnt     <= r_cnt + W'(1);
          end
        end
        S_SEND_DATA: begin
          r_frame_xor <= r_frame_xor ^ r_tx_data;
          if (r_cnt == D_LAST) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_wd       <= '0;
            r_state    <= S_WAIT_RES;
          end else begin
            r_tx_data <= r_lfsr[15:0];
            r_lfsr    <= w_lfsr_next;
            r_cnt     <= r_cnt + W'(1);
          end
        end
        S_WAIT_RES: begin
          if (rx_valid) begin
            r_result <= {rx_data, r_result[RW-1:16]};
            r_cnt    <= W'(1);
            r_state  <= S_CAPTURE;
          end else if (r_wd == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_wd <= r_wd + 24'd1;
          end
        end
        S_CAPTURE: begin
          // Result words shift in from the top so r0 ends up in the low slot.
          if (rx_valid) begin
            r_result <= {rx_data, r_result[RW-1:16]};
            if (r_cnt == C_LAST) begin
              r_result_valid <= 1'b1;
              r_done         <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_cnt <= r_cnt + W'(1);
            end
          end else begin
            r_proto_err <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign done         = r_done;
  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign timeout_err  = r_timeout_err;
  assign proto_err    = r_proto_err;
  assign frame_xor    = r_frame_xor;

endmodule
